// File: rtl/cpu_debug_ctrl.sv
// Run-control and program loader for a single-cycle CPU: loads instruction memory, then supervises run/step/halt.
// Breakpoint registers and comparators are built only when DBG_BP_EN is defined.
module cpu_debug_ctrl #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8,
  parameter int NUM_BP = 2,
  parameter int CNT_W  = 16,
  localparam int BP_IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [DATA_W-1:0]   ld_data,
  input  logic                cmd_valid,
  input  logic [1:0]          cmd,
  input  logic                bp_we,
  input  logic [BP_IDX_W-1:0] bp_idx,
  input  logic [ADDR_W-1:0]   bp_addr,
  input  logic                bp_en,
  input  logic [CNT_W-1:0]    max_cycles,
  input  logic [ADDR_W-1:0]   pc_in,
  input  logic [DATA_W-1:0]   ir_in,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic                cpu_rstn,
  output logic                cpu_en,
  output logic [1:0]          state,
  output logic [1:0]          halt_cause,
  output logic [CNT_W-1:0]    cycle_cnt,
  output logic [DATA_W-1:0]   last_ir
);

  typedef enum logic [1:0] {
    ST_LOAD = 2'b00,
    ST_RUN  = 2'b01,
    ST_HALT = 2'b10,
    ST_STEP = 2'b11
  } state_e;

  localparam logic [1:0] CMD_RUN   = 2'b00;
  localparam logic [1:0] CMD_STEP  = 2'b01;
  localparam logic [1:0] CMD_HALT  = 2'b10;
  localparam logic [1:0] CMD_RESET = 2'b11;

  localparam logic [1:0] CAUSE_NONE  = 2'b00;
  localparam logic [1:0] CAUSE_BP    = 2'b01;
  localparam logic [1:0] CAUSE_LIMIT = 2'b10;
  localparam logic [1:0] CAUSE_HOST  = 2'b11;

  state_e              state_q, state_d;
  logic [1:0]          cause_q, cause_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   ir_q, ir_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                resume_q, resume_d;

  logic ld_fire;
  logic bp_hit;
  logic limit_hit;
  logic host_halt;
  logic stop;
  logic cpu_en_w;

  // Load handshake: a beat transfers on an edge where ld_valid and ld_ready are both high;
  // ld_ready is high only in LOAD with no command pending, so commands always win over beats.
  assign ld_ready = (state_q == ST_LOAD) && !cmd_valid;
  assign ld_fire  = ld_valid && ld_ready;

`ifdef DBG_BP_EN
  logic [ADDR_W-1:0] bp_addr_q [NUM_BP];
  logic [NUM_BP-1:0] bp_en_q;
  logic [NUM_BP-1:0] bp_match;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NUM_BP; i++) bp_addr_q[i] <= '0;
      bp_en_q <= '0;
    end else if (bp_we && (int'(bp_idx) < NUM_BP)) begin
      bp_addr_q[bp_idx] <= bp_addr;
      bp_en_q[bp_idx]   <= bp_en;
    end
  end

  always_comb begin
    bp_match = '0;
    for (int i = 0; i < NUM_BP; i++) bp_match[i] = bp_en_q[i] && (bp_addr_q[i] == pc_in);
  end

  // The first RUN cycle after a resume ignores breakpoints so the CPU can leave the halt PC.
  assign bp_hit = (|bp_match) && !resume_q;
`else
  logic unused_bp;
  assign unused_bp = ^{bp_we, bp_idx, bp_addr, bp_en};
  assign bp_hit    = 1'b0;
`endif

  assign limit_hit = (max_cycles != '0) && (cnt_q == max_cycles);
  assign host_halt = cmd_valid && (cmd == CMD_HALT);
  assign stop      = bp_hit || limit_hit || host_halt;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_LOAD;
      cause_q  <= CAUSE_NONE;
      cnt_q    <= '0;
      ir_q     <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      resume_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cause_q  <= cause_d;
      cnt_q    <= cnt_d;
      ir_q     <= ir_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      resume_q <= resume_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cause_d  = cause_q;
    cnt_d    = cnt_q;
    ir_d     = ir_q;
    resume_d = 1'b0;
    we_d     = ld_fire;
    addr_d   = addr_q;
    wdata_d  = wdata_q;

    if (ld_fire) begin
      addr_d  = ld_addr;
      wdata_d = ld_data;
    end

    if (cpu_en_w) begin
      if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      ir_d = ir_in;
    end

    case (state_q)
      ST_LOAD: begin
        if (cmd_valid && (cmd == CMD_RUN)) begin
          state_d = ST_RUN;
          cnt_d   = '0;
          cause_d = CAUSE_NONE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_d = ST_HALT;
          if (bp_hit)         cause_d = CAUSE_BP;
          else if (limit_hit) cause_d = CAUSE_LIMIT;
          else                cause_d = CAUSE_HOST;
        end
      end
      ST_HALT: begin
        if (cmd_valid && (cmd == CMD_RUN)) begin
          state_d  = ST_RUN;
          resume_d = 1'b1;
        end else if (cmd_valid && (cmd == CMD_STEP)) begin
          state_d = ST_STEP;
        end
      end
      default: state_d = ST_HALT;
    endcase

    // RESET overrides everything else but deliberately leaves the breakpoint registers alone.
    if (cmd_valid && (cmd == CMD_RESET)) begin
      state_d  = ST_LOAD;
      cnt_d    = '0;
      cause_d  = CAUSE_NONE;
      ir_d     = '0;
      resume_d = 1'b0;
    end
  end

  always_comb begin
    cpu_en_w = 1'b0;
    case (state_q)
      ST_RUN:  cpu_en_w = !stop;
      ST_STEP: cpu_en_w = 1'b1;
      default: cpu_en_w = 1'b0;
    endcase
  end

  assign cpu_en     = cpu_en_w;
  assign cpu_rstn   = (state_q != ST_LOAD);
  assign state      = state_q;
  assign halt_cause = cause_q;
  assign cycle_cnt  = cnt_q;
  assign last_ir    = ir_q;
  assign mem_we     = we_q;
  assign mem_addr   = addr_q;
  assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_cpu_debug_ctrl.sv
// Directed + randomized bench for cpu_debug_ctrl with a toy CPU (PC counter over a random program image)
// and a run-length predictor derived from the stop rules.
module tb_cpu_debug_ctrl;

  localparam int NUM_BP = 2;
`ifdef DBG_BP_EN
  localparam bit BP_BUILT = 1'b1;
`else
  localparam bit BP_BUILT = 1'b0;
`endif

  localparam logic [1:0] CMD_RUN = 2'b00, CMD_STEP = 2'b01, CMD_HALT = 2'b10, CMD_RESET = 2'b11;
  localparam int S_LOAD = 0, S_RUN = 1, S_HALT = 2, S_STEP = 3;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ld_valid = 1'b0;
  logic        ld_ready;
  logic [7:0]  ld_addr = '0;
  logic [7:0]  ld_data = '0;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd = '0;
  logic        bp_we = 1'b0;
  logic [0:0]  bp_idx = '0;
  logic [7:0]  bp_addr = '0;
  logic        bp_en = 1'b0;
  logic [15:0] max_cycles = '0;
  logic [7:0]  pc_in;
  logic [7:0]  ir_in;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_wdata;
  logic        cpu_rstn;
  logic        cpu_en;
  logic [1:0]  state;
  logic [1:0]  halt_cause;
  logic [15:0] cycle_cnt;
  logic [7:0]  last_ir;

  cpu_debug_ctrl #(.DATA_W(8), .ADDR_W(8), .NUM_BP(NUM_BP), .CNT_W(16)) dut (
    .clk(clk), .rstn(rstn),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .cmd_valid(cmd_valid), .cmd(cmd),
    .bp_we(bp_we), .bp_idx(bp_idx), .bp_addr(bp_addr), .bp_en(bp_en),
    .max_cycles(max_cycles), .pc_in(pc_in), .ir_in(ir_in),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_rstn(cpu_rstn), .cpu_en(cpu_en), .state(state), .halt_cause(halt_cause),
    .cycle_cnt(cycle_cnt), .last_ir(last_ir)
  );

  always #5 clk = ~clk;

  // Toy CPU: PC advances on every enabled edge, IR is the program byte at the PC.
  logic [7:0] prog [256];
  logic [7:0] cpu_pc = 8'd0;
  assign pc_in = cpu_pc;
  assign ir_in = prog[cpu_pc];

  always @(posedge clk or negedge rstn) begin
    if (!rstn)         cpu_pc <= 8'd0;
    else if (!cpu_rstn) cpu_pc <= 8'd0;
    else if (cpu_en)   cpu_pc <= cpu_pc + 8'd1;
  end

  int n_checks = 0;
  int n_pass = 0;

  logic [7:0] bp_a [NUM_BP];
  bit         bp_e [NUM_BP];
  int         exp_cnt = 0;
  logic [7:0] exp_ir = '0;
  int         exp_cause = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_cmd(input logic [1:0] c);
    cmd_valid = 1'b1;
    cmd = c;
    tick();
    cmd_valid = 1'b0;
    if (c == CMD_RESET) begin
      exp_cnt = 0;
      exp_ir = '0;
      exp_cause = 0;
    end
  endtask

  task automatic bp_write(input int idx, input logic [7:0] a, input bit en);
    bp_we = 1'b1;
    bp_idx = 1'(idx);
    bp_addr = a;
    bp_en = en;
    tick();
    bp_we = 1'b0;
    if (BP_BUILT) begin
      bp_a[idx] = a;
      bp_e[idx] = en;
    end
  endtask

  // Walks the PC sequence from the start point and applies the stop rules in priority order.
  function automatic void predict(input logic [7:0] spc, input int scnt, input int lim, input bit mask,
                                  input int host_after, output int n, output int cause);
    logic [7:0] pc;
    int cnt;
    bit hit;
    n = 0;
    cause = 0;
    pc = spc;
    cnt = scnt;
    for (int g = 0; g < 1000; g++) begin
      hit = 1'b0;
      if (BP_BUILT && !(mask && n == 0))
        for (int i = 0; i < NUM_BP; i++) if (bp_e[i] && bp_a[i] == pc) hit = 1'b1;
      if (hit) begin cause = 1; return; end
      if (lim != 0 && cnt == lim) begin cause = 2; return; end
      if (n == host_after) begin cause = 3; return; end
      n++;
      pc = pc + 8'd1;
      cnt = (cnt == 65535) ? cnt : cnt + 1;
    end
  endfunction

  task automatic run_phase(input string tag, input bit from_load, input int host_after);
    logic [7:0] spc, stop_pc;
    int n_pred, c_pred, n_obs;
    bit done;
    spc = from_load ? 8'd0 : cpu_pc;
    if (from_load) exp_cnt = 0;
    predict(spc, exp_cnt, int'(max_cycles), !from_load, host_after, n_pred, c_pred);
    stop_pc = spc + 8'(n_pred);
    do_cmd(CMD_RUN);
    n_obs = 0;
    done = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      if (n_obs == host_after) begin cmd_valid = 1'b1; cmd = CMD_HALT; end
      #1;
      if (state != 2'(S_RUN)) done = 1'b1;
      else begin
        if (cpu_en) n_obs++;
        else check({tag, "_stop_pc"}, pc_in, stop_pc);
        tick();
        cmd_valid = 1'b0;
      end
    end
    cmd_valid = 1'b0;
    check({tag, "_halted_in_budget"}, done, 1);
    exp_cnt += n_pred;
    if (n_pred > 0) exp_ir = prog[spc + 8'(n_pred - 1)];
    exp_cause = c_pred;
    check({tag, "_en_cycles"}, n_obs, n_pred);
    check({tag, "_state"}, state, S_HALT);
    check({tag, "_cause"}, halt_cause, exp_cause);
    check({tag, "_cycle_cnt"}, cycle_cnt, exp_cnt);
    check({tag, "_last_ir"}, last_ir, exp_ir);
    check({tag, "_cpu_rstn"}, cpu_rstn, 1);
    check({tag, "_cpu_en"}, cpu_en, 0);
  endtask

  task automatic step_phase(input string tag);
    logic [7:0] p;
    p = cpu_pc;
    do_cmd(CMD_STEP);
    check({tag, "_state_step"}, state, S_STEP);
    check({tag, "_en_step"}, cpu_en, 1);
    tick();
    exp_cnt++;
    exp_ir = prog[p];
    check({tag, "_state_back"}, state, S_HALT);
    check({tag, "_en_after"}, cpu_en, 0);
    check({tag, "_cycle_cnt"}, cycle_cnt, exp_cnt);
    check({tag, "_last_ir"}, last_ir, exp_ir);
    check({tag, "_cause_kept"}, halt_cause, exp_cause);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, state, S_LOAD);
    check({tag, "_cpu_rstn"}, cpu_rstn, 0);
    check({tag, "_cpu_en"}, cpu_en, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_ld_ready"}, ld_ready, 1);
    check({tag, "_cause"}, halt_cause, 0);
    check({tag, "_cycle_cnt"}, cycle_cnt, 0);
    check({tag, "_last_ir"}, last_ir, 0);
  endtask

  logic [7:0] beats [4];

  initial begin
    for (int i = 0; i < 256; i++) prog[i] = 8'($urandom);
    for (int i = 0; i < NUM_BP; i++) begin bp_a[i] = '0; bp_e[i] = 1'b0; end
    beats[0] = 8'h88; beats[1] = 8'h89; beats[2] = 8'h24; beats[3] = 8'h39;
    for (int i = 0; i < 4; i++) prog[i] = beats[i];

    #2;
    check_reset_values("por");
    #10 rstn = 1'b1;
    tick();

    // Back-to-back load of four bytes.
    for (int i = 0; i < 4; i++) begin
      ld_valid = 1'b1;
      ld_addr = 8'(i);
      ld_data = beats[i];
      #1;
      check("ld_ready_idle", ld_ready, 1);
      tick();
      check("ld_mem_we", mem_we, 1);
      check("ld_mem_addr", mem_addr, i);
      check("ld_mem_wdata", mem_wdata, beats[i]);
    end
    ld_valid = 1'b0;
    tick();
    check("ld_we_drop", mem_we, 0);

    // A pending command blocks the load beat; HALT and STEP in LOAD are no-ops.
    ld_valid = 1'b1;
    ld_addr = 8'h40;
    cmd_valid = 1'b1;
    cmd = CMD_HALT;
    #1;
    check("ld_ready_cmd", ld_ready, 0);
    tick();
    cmd_valid = 1'b0;
    ld_valid = 1'b0;
    check("ld_blocked_we", mem_we, 0);
    check("halt_in_load_state", state, S_LOAD);
    do_cmd(CMD_STEP);
    check("step_in_load_state", state, S_LOAD);
    check("step_in_load_en", cpu_en, 0);

    bp_write(0, 8'h03, 1'b1);
    max_cycles = 16'd0;
    run_phase("bp_run", 1'b1, BP_BUILT ? 100 : 6);

    do_cmd(CMD_HALT);
    check("halt_in_halt_state", state, S_HALT);
    check("halt_in_halt_cause", halt_cause, exp_cause);

    step_phase("step");
    run_phase("resume", 1'b0, 5);

    do_cmd(CMD_RESET);
    check("rst_cmd_state", state, S_LOAD);
    check("rst_cmd_cpu_rstn", cpu_rstn, 0);
    check("rst_cmd_cnt", cycle_cnt, 0);
    check("rst_cmd_cause", halt_cause, 0);
    check("rst_cmd_last_ir", last_ir, 0);

    bp_write(0, 8'h03, 1'b0);
    max_cycles = 16'd5;
    run_phase("limit", 1'b1, 100);

    do_cmd(CMD_RESET);
    bp_write(0, 8'h03, 1'b1);
    max_cycles = 16'd3;
    run_phase("coincide", 1'b1, 100);

    max_cycles = 16'd0;
    run_phase("resume_bp", 1'b0, 4);

    do_cmd(CMD_RESET);
    check("rst_in_halt_state", state, S_LOAD);
    run_phase("bp_kept", 1'b1, BP_BUILT ? 100 : 7);

    for (int it = 0; it < 8; it++) begin
      bp_write(int'($urandom_range(0, NUM_BP - 1)), 8'($urandom_range(0, 12)), 1'($urandom_range(0, 1)));
      max_cycles = 16'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        do_cmd(CMD_RESET);
        run_phase("rnd_load", 1'b1, int'($urandom_range(1, 20)));
      end else begin
        run_phase("rnd_resume", 1'b0, int'($urandom_range(1, 20)));
      end
      if (it % 3 == 2) step_phase("rnd_step");
    end

    // Asynchronous reset in the middle of a run.
    bp_write(0, 8'h00, 1'b0);
    bp_write(1, 8'h05, 1'b1);
    max_cycles = 16'd0;
    do_cmd(CMD_RESET);
    do_cmd(CMD_RUN);
    tick();
    tick();
    check("mid_run_en", cpu_en, 1);
    #3 rstn = 1'b0;
    #1;
    check_reset_values("async");
    for (int i = 0; i < NUM_BP; i++) begin bp_a[i] = '0; bp_e[i] = 1'b0; end
    exp_cnt = 0;
    exp_ir = '0;
    exp_cause = 0;
    #2 rstn = 1'b1;
    tick();
    run_phase("post_rst", 1'b1, 8);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
